// File: rtl/multiexp_feeder.sv
// multiexp_feeder
//   Source end of the multiexp point/scalar stream. A job starts with a
//   one-cycle i_start carrying the pair count. The feeder then captures that
//   many {point,scalar} pairs from the host load stream into local RAM. It
//   replays them SCL_BITS times, in index order, to the multiexp engine. It
//   accepts the single result point from the engine and forwards it to the
//   host.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start, i_num_in       job start pulse (IDLE only) and pair count
//   i_load_if_*             host pair stream in (dat = {point,scalar})
//   o_pnt_scl_if_*          replay stream to engine (scalar in LSBs)
//   i_res_if_*              result point from engine
//   o_res_if_*              result point to host (single beat, sop=eop=1)
//   o_busy                  high whenever a job is in progress
//   o_err                   one-cycle pulse when a start is rejected
module multiexp_feeder #(
  parameter int PNT_BITS = 768,
  parameter int SCL_BITS = 256,
  parameter int DEPTH    = 1024,
  parameter int CTL_BITS = 8
) (
  input  logic                                            i_clk,
  input  logic                                            i_rst_n,
  input  logic                                            i_start,
  input  logic [$clog2(DEPTH):0]                          i_num_in,

  input  logic [PNT_BITS+SCL_BITS-1:0]                    i_load_if_dat,
  input  logic                                            i_load_if_val,
  output logic                                            i_load_if_rdy,

  output logic [PNT_BITS+SCL_BITS-1:0]                    o_pnt_scl_if_dat,
  output logic                                            o_pnt_scl_if_val,
  input  logic                                            o_pnt_scl_if_rdy,
  output logic                                            o_pnt_scl_if_sop,
  output logic                                            o_pnt_scl_if_eop,
  output logic [CTL_BITS-1:0]                             o_pnt_scl_if_ctl,
  output logic                                            o_pnt_scl_if_err,
  output logic [$clog2((PNT_BITS+SCL_BITS)/8)-1:0]        o_pnt_scl_if_mod,

  input  logic [PNT_BITS-1:0]                             i_res_if_dat,
  input  logic                                            i_res_if_val,
  output logic                                            i_res_if_rdy,

  output logic [PNT_BITS-1:0]                             o_res_if_dat,
  output logic                                            o_res_if_val,
  input  logic                                            o_res_if_rdy,
  output logic                                            o_res_if_sop,
  output logic                                            o_res_if_eop,
  output logic [CTL_BITS-1:0]                             o_res_if_ctl,
  output logic                                            o_res_if_err,
  output logic [$clog2(PNT_BITS/8)-1:0]                   o_res_if_mod,

  output logic                                            o_busy,
  output logic                                            o_err
);

  localparam int DW     = PNT_BITS + SCL_BITS;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int NUM_W  = IDX_W + 1;
  localparam int PASS_W = $clog2(SCL_BITS);
  localparam int FW     = DW + 3;

  typedef enum logic [2:0] {IDLE, LOAD, REPLAY, WAIT_RES, OUT} state_t;

  state_t             state, state_nxt;
  logic [NUM_W-1:0]   num_in;
  logic [IDX_W-1:0]   idx;
  logic [PASS_W-1:0]  pass;
  logic               issue_done;
  logic               err_set;
  logic               busy;
  logic               load_rdy;
  logic               res_in_rdy;

  logic [DW-1:0]      ram [DEPTH];
  logic [DW-1:0]      ram_q;
  logic               rd_vld, rd_sop, rd_eop, rd_last;

  logic [FW-1:0]      fifo_mem [2];
  logic               fifo_wr_ptr, fifo_rd_ptr;
  logic [1:0]         fifo_cnt;
  logic [1:0]         fifo_after;
  logic [FW-1:0]      fifo_head;
  logic               fifo_pop;

  logic [DW-1:0]      ps_dat;
  logic               ps_val, ps_sop, ps_eop, ps_last;
  logic [PNT_BITS-1:0] res_dat;
  logic               res_val;

  logic start_ok, idx_last, pass_last;
  logic load_fire, issue, ps_fire, res_in_fire, res_out_fire;

  assign start_ok  = (i_num_in != '0) && (i_num_in <= NUM_W'(DEPTH));
  assign idx_last  = ({1'b0, idx} == (num_in - NUM_W'(1)));
  assign pass_last = (pass == PASS_W'(SCL_BITS - 1));

  assign load_fire    = (state == LOAD) && i_load_if_val;
  assign ps_fire      = ps_val && o_pnt_scl_if_rdy;
  assign res_in_fire  = i_res_if_val && res_in_rdy;
  assign res_out_fire = res_val && o_res_if_rdy;

  // The output register refills from the skid buffer whenever it is empty or
  // its current beat is leaving this cycle.
  assign fifo_pop  = (fifo_cnt != 2'd0) && (!ps_val || o_pnt_scl_if_rdy);
  assign fifo_head = fifo_mem[fifo_rd_ptr];

  // A RAM read is issued only if the beat it returns next cycle is guaranteed
  // a free skid slot. That is the buffer occupancy after this edge (including
  // the read already in flight) minus what the output register drains.
  assign fifo_after = fifo_cnt + 2'(rd_vld) - 2'(fifo_pop);
  assign issue      = (state == REPLAY) && !issue_done && (fifo_after < 2'd2);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and handshake-ready decode.
  always_comb begin
    state_nxt  = state;
    load_rdy   = 1'b0;
    res_in_rdy = 1'b0;
    busy       = 1'b1;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (i_start) begin
          if (start_ok) state_nxt = LOAD;
          else          err_set   = 1'b1;
        end
      end
      LOAD: begin
        load_rdy = 1'b1;
        if (i_load_if_val && idx_last) state_nxt = REPLAY;
      end
      REPLAY: begin
        if (ps_fire && ps_last) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        res_in_rdy = !res_val;
        if (res_in_fire) state_nxt = OUT;
      end
      OUT: begin
        if (res_out_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A single index serves both as the load write pointer and the replay read
  // pointer. The pass counter and issue_done track how far replay issue has
  // progressed. Replay issue runs ahead of the output by the prefetch depth.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      num_in     <= '0;
      idx        <= '0;
      pass       <= '0;
      issue_done <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_err <= err_set;
      if ((state == IDLE) && i_start && start_ok) begin
        num_in <= i_num_in;
        idx    <= '0;
      end else if (load_fire) begin
        if (idx_last) begin
          idx        <= '0;
          pass       <= '0;
          issue_done <= 1'b0;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end else if (issue) begin
        if (idx_last) begin
          idx <= '0;
          if (pass_last) begin
            pass       <= '0;
            issue_done <= 1'b1;
          end else begin
            pass <= pass + PASS_W'(1);
          end
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

  // Pair storage with one-cycle synchronous read; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (load_fire) ram[idx] <= i_load_if_dat;
    if (issue)     ram_q    <= ram[idx];
  end

  // Framing flags travel alongside the RAM read so they land in the skid
  // buffer together with their data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_vld  <= 1'b0;
      rd_sop  <= 1'b0;
      rd_eop  <= 1'b0;
      rd_last <= 1'b0;
    end else begin
      rd_vld  <= issue;
      rd_sop  <= (idx == '0);
      rd_eop  <= idx_last;
      rd_last <= idx_last && pass_last;
    end
  end

  // Two-entry skid buffer storage.
  always_ff @(posedge i_clk) begin
    if (rd_vld) fifo_mem[fifo_wr_ptr] <= {rd_last, rd_eop, rd_sop, ram_q};
  end

  // Skid buffer pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fifo_wr_ptr <= 1'b0;
      fifo_rd_ptr <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      fifo_wr_ptr <= fifo_wr_ptr ^ rd_vld;
      fifo_rd_ptr <= fifo_rd_ptr ^ fifo_pop;
      fifo_cnt    <= fifo_after;
    end
  end

  // Engine-facing output register. It is held while stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ps_val  <= 1'b0;
      ps_dat  <= '0;
      ps_sop  <= 1'b0;
      ps_eop  <= 1'b0;
      ps_last <= 1'b0;
    end else if (fifo_pop) begin
      ps_val <= 1'b1;
      {ps_last, ps_eop, ps_sop, ps_dat} <= fifo_head;
    end else if (ps_fire) begin
      ps_val <= 1'b0;
    end
  end

  // Result holding register toward the host.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res_val <= 1'b0;
      res_dat <= '0;
    end else if (res_in_fire) begin
      res_val <= 1'b1;
      res_dat <= i_res_if_dat;
    end else if (res_out_fire) begin
      res_val <= 1'b0;
    end
  end

  assign i_load_if_rdy    = load_rdy;
  assign i_res_if_rdy     = res_in_rdy;
  assign o_busy           = busy;

  assign o_pnt_scl_if_dat = ps_dat;
  assign o_pnt_scl_if_val = ps_val;
  assign o_pnt_scl_if_sop = ps_sop;
  assign o_pnt_scl_if_eop = ps_eop;
  assign o_pnt_scl_if_ctl = '0;
  assign o_pnt_scl_if_err = 1'b0;
  assign o_pnt_scl_if_mod = '0;

  assign o_res_if_dat     = res_dat;
  assign o_res_if_val     = res_val;
  assign o_res_if_sop     = 1'b1;
  assign o_res_if_eop     = 1'b1;
  assign o_res_if_ctl     = '0;
  assign o_res_if_err     = 1'b0;
  assign o_res_if_mod     = '0;

endmodule

// File: tb/tb_multiexp_feeder.sv
// tb_multiexp_feeder
//   Self-checking bench for multiexp_feeder with PNT_BITS=16, SCL_BITS=8,
//   DEPTH=8. Jobs use fixed or $urandom pair data. The expected replay
//   sequence is built as a queue of beats: every pass visits every stored
//   pair in index order. Each engine handshake pops one expected beat.
module tb_multiexp_feeder;

  localparam int PNT = 16;
  localparam int SCL = 8;
  localparam int DEP = 8;
  localparam int DW  = PNT + SCL;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [3:0]    num_in;
  logic [DW-1:0] load_dat;
  logic          load_val, load_rdy;
  logic [DW-1:0] ps_dat;
  logic          ps_val, ps_rdy, ps_sop, ps_eop, ps_err;
  logic [7:0]    ps_ctl;
  logic [1:0]    ps_mod;
  logic [PNT-1:0] res_in_dat;
  logic          res_in_val, res_in_rdy;
  logic [PNT-1:0] res_dat;
  logic          res_val, res_rdy, res_sop, res_eop, res_err;
  logic [7:0]    res_ctl;
  logic [0:0]    res_mod;
  logic          busy, err_pulse;

  typedef struct {
    logic [DW-1:0] dat;
    logic          sop;
    logic          eop;
  } beat_t;

  beat_t         expq[$];
  logic [DW-1:0] pairs[$];
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  multiexp_feeder #(.PNT_BITS(PNT), .SCL_BITS(SCL), .DEPTH(DEP), .CTL_BITS(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_num_in(num_in),
    .i_load_if_dat(load_dat), .i_load_if_val(load_val), .i_load_if_rdy(load_rdy),
    .o_pnt_scl_if_dat(ps_dat), .o_pnt_scl_if_val(ps_val), .o_pnt_scl_if_rdy(ps_rdy),
    .o_pnt_scl_if_sop(ps_sop), .o_pnt_scl_if_eop(ps_eop), .o_pnt_scl_if_ctl(ps_ctl),
    .o_pnt_scl_if_err(ps_err), .o_pnt_scl_if_mod(ps_mod),
    .i_res_if_dat(res_in_dat), .i_res_if_val(res_in_val), .i_res_if_rdy(res_in_rdy),
    .o_res_if_dat(res_dat), .o_res_if_val(res_val), .o_res_if_rdy(res_rdy),
    .o_res_if_sop(res_sop), .o_res_if_eop(res_eop), .o_res_if_ctl(res_ctl),
    .o_res_if_err(res_err), .o_res_if_mod(res_mod),
    .o_busy(busy), .o_err(err_pulse)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startJob(input int n);
    start  = 1'b1;
    num_in = 4'(n);
    tick();
    start  = 1'b0;
    num_in = 4'd0;
  endtask

  // Starts a job of n pairs, loads them, and queues the expected replay.
  task automatic applyStimulus(input int n, input bit fixed_data);
    beat_t b;
    int    k;
    pairs.delete();
    expq.delete();
    for (int i = 0; i < n; i++)
      pairs.push_back(fixed_data ? DW'(32'h10 + i) : DW'($urandom));
    for (int p = 0; p < SCL; p++)
      for (int i = 0; i < n; i++) begin
        b.dat = pairs[i];
        b.sop = (i == 0);
        b.eop = (i == n - 1);
        expq.push_back(b);
      end
    startJob(n);
    checkOutput("busy_after_start", {63'd0, busy}, 64'd1);
    for (int i = 0; i < n; i++) begin
      load_val = 1'b1;
      load_dat = pairs[i];
      k = 0;
      while (!load_rdy && k < 50) begin
        tick();
        k++;
      end
      if (k >= 50) checkOutput("load_timeout", 64'd1, 64'd0);
      tick();
    end
    load_val = 1'b0;
  endtask

  // Drains replay beats against the expected queue with random backpressure.
  task automatic runReplay(input int bp_pct, input bit check_rate, input int stop_after);
    beat_t         e;
    int            cycles = 0;
    int            first = -1;
    int            lastc = 0;
    int            beats = 0;
    int            total;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_dat = '0;
    total = expq.size();
    while (expq.size() > 0 && (stop_after == 0 || beats < stop_after) && cycles < 4000) begin
      ps_rdy = ($urandom_range(99) >= bp_pct);
      if (cycles == 0) checkOutput("res_rdy_in_replay", {63'd0, res_in_rdy}, 64'd0);
      if (prev_stall) checkOutput("stall_hold", {ps_val, ps_dat}, {1'b1, prev_dat});
      if (ps_val && first < 0) first = cycles;
      if (ps_val && ps_rdy) begin
        e = expq.pop_front();
        checkOutput("beat", {ps_dat, ps_sop, ps_eop, ps_ctl, ps_err, ps_mod},
                    {e.dat, e.sop, e.eop, 11'd0});
        beats++;
        lastc = cycles;
      end
      prev_stall = ps_val && !ps_rdy;
      prev_dat   = ps_dat;
      tick();
      cycles++;
    end
    ps_rdy = 1'b0;
    if (cycles >= 4000) checkOutput("replay_timeout", 64'd1, 64'd0);
    if (check_rate) begin
      checkOutput("first_beat_latency", {63'd0, (first >= 0 && first <= 3)}, 64'd1);
      checkOutput("beats_per_cycle", 64'(lastc - first), 64'(total - 1));
    end
  endtask

  // Supplies the engine result and lets the host stall it for hold cycles.
  task automatic resultPhase(input logic [PNT-1:0] value, input int hold);
    int k = 0;
    checkOutput("busy_wait_res", {63'd0, busy}, 64'd1);
    res_in_val = 1'b1;
    res_in_dat = value;
    while (!res_in_rdy && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) checkOutput("res_in_timeout", 64'd1, 64'd0);
    tick();
    res_in_val = 1'b0;
    res_rdy    = 1'b0;
    for (int i = 0; i < hold; i++) begin
      checkOutput("res_hold", {res_in_rdy, res_val, res_sop, res_eop, res_dat},
                  {1'b0, 1'b1, 1'b1, 1'b1, value});
      tick();
    end
    checkOutput("res_final", {res_val, res_dat}, {1'b1, value});
    res_rdy = 1'b1;
    tick();
    res_rdy = 1'b0;
    checkOutput("res_done_idle", {62'd0, res_val, busy}, 64'd0);
  endtask

  task automatic rejectStart(input int n, input string tag);
    int pulses = 0;
    bit active = 1'b0;
    startJob(n);
    for (int i = 0; i < 3; i++) begin
      pulses += int'(err_pulse);
      active |= busy | load_rdy;
      tick();
    end
    checkOutput({tag, "_err_pulses"}, 64'(pulses), 64'd1);
    checkOutput({tag, "_no_activity"}, {63'd0, active}, 64'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; num_in = '0; load_dat = '0; load_val = 1'b0;
    ps_rdy = 1'b0; res_in_dat = '0; res_in_val = 1'b0; res_rdy = 1'b0;
    repeat (3) tick();
    checkOutput("reset_state", {59'd0, ps_val, res_val, load_rdy, res_in_rdy, busy}, 64'd0);
    checkOutput("reset_err", {63'd0, err_pulse}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("[TB] job of 4 fixed pairs, no backpressure");
    applyStimulus(4, 1'b1);
    runReplay(0, 1'b1, 0);
    resultPhase(16'hBEEF, 5);

    $display("[TB] same job with backpressure and stray start");
    applyStimulus(4, 1'b1);
    start = 1'b1; num_in = 4'd0;
    tick();
    start = 1'b0;
    checkOutput("start_ignored_busy", {62'd0, err_pulse, busy}, 64'd1);
    runReplay(30, 1'b0, 0);
    resultPhase(16'(($urandom)), 2);

    $display("[TB] rejected starts");
    rejectStart(0, "num0");
    rejectStart(9, "num9");

    $display("[TB] full depth and single pair");
    applyStimulus(8, 1'b0);
    runReplay(0, 1'b1, 0);
    resultPhase(16'(($urandom)), 0);
    applyStimulus(1, 1'b0);
    runReplay(0, 1'b1, 0);
    resultPhase(16'(($urandom)), 1);

    $display("[TB] random jobs");
    for (int j = 0; j < 3; j++) begin
      n = int'($urandom_range(1, DEP));
      applyStimulus(n, 1'b0);
      runReplay(int'($urandom_range(0, 50)), 1'b0, 0);
      resultPhase(16'(($urandom)), int'($urandom_range(0, 3)));
    end

    $display("[TB] reset mid replay");
    applyStimulus(4, 1'b1);
    runReplay(0, 1'b0, 13);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midjob_reset", {59'd0, ps_val, res_val, load_rdy, res_in_rdy, busy}, 64'd0);
    expq.delete();
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    applyStimulus(3, 1'b0);
    runReplay(20, 1'b0, 0);
    resultPhase(16'(($urandom)), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
